// File: rtl/data_req_splitter.sv
`default_nettype none
// ============================================================================
// Module      : data_req_splitter
// Description : Bridges the core's single SRAM-like data port onto the AXI
//               bridge's split read/write request ports. Each accepted
//               request is steered to the read or write channel. Responses
//               are returned to the core strictly in issue order. A read is
//               held off while any write is still undelivered, so reads
//               always observe earlier writes.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   OUTSTANDING : max accepted-but-undelivered requests (power of 2, 2..16)
//   PTR_W       : log2(OUTSTANDING)
// Ports
//   clk, resetn                   : clock, asynchronous active-low reset
//   data_req/wr/size/addr/wdata   : core request side
//   data_addr_ok                  : core request accepted this cycle
//   data_data_ok, data_rdata      : in-order completion to the core
//   rd_req/size/addr, rd_addr_ok  : read request to the bridge
//   rd_data_ok, rd_rdata          : read response from the bridge
//   wr_req/size/addr/wdata,
//   wr_addr_ok                    : write request to the bridge
//   wr_data_ok                    : write response from the bridge
//   busy                          : any request outstanding
// ============================================================================
module data_req_splitter #(
    parameter int OUTSTANDING = 4,
    parameter int PTR_W       = 2
) (
    input  logic        clk,
    input  logic        resetn,
    // core side
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    // bridge read channel
    output logic        rd_req,
    output logic [1:0]  rd_size,
    output logic [31:0] rd_addr,
    input  logic        rd_addr_ok,
    input  logic        rd_data_ok,
    input  logic [31:0] rd_rdata,
    // bridge write channel
    output logic        wr_req,
    output logic [1:0]  wr_size,
    output logic [31:0] wr_addr,
    output logic [31:0] wr_wdata,
    input  logic        wr_addr_ok,
    input  logic        wr_data_ok,
    // status
    output logic        busy
);

    // Counters must be able to hold the value OUTSTANDING itself.
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(OUTSTANDING);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_zero = '0;
    localparam logic [PTR_W-1:0] c_ptr_one  = PTR_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    // Order FIFO: one bit per accepted request, 1 = write.
    logic             ord_type_q [OUTSTANDING];
    logic             ord_type_d [OUTSTANDING];
    logic [PTR_W-1:0] ord_wp_q, ord_wp_d;
    logic [PTR_W-1:0] ord_rp_q, ord_rp_d;
    logic [CNT_W-1:0] ord_cnt_q, ord_cnt_d;

    // Read data FIFO: captured read responses awaiting delivery.
    logic [31:0]      rdf_mem_q [OUTSTANDING];
    logic [31:0]      rdf_mem_d [OUTSTANDING];
    logic [PTR_W-1:0] rdf_wp_q, rdf_wp_d;
    logic [PTR_W-1:0] rdf_rp_q, rdf_rp_d;
    logic [CNT_W-1:0] rdf_cnt_q, rdf_cnt_d;

    // wr_out : writes accepted but not yet delivered to the core
    // rd_iss : reads issued to the bridge whose response is not captured
    // wr_iss : writes issued to the bridge whose response is not captured
    // wr_done: write responses captured but not yet delivered
    logic [CNT_W-1:0] wr_out_q,  wr_out_d;
    logic [CNT_W-1:0] rd_iss_q,  rd_iss_d;
    logic [CNT_W-1:0] wr_iss_q,  wr_iss_d;
    logic [CNT_W-1:0] wr_done_q, wr_done_d;

    // ------------------------------------------------------------------
    // Issue, capture and delivery qualifiers
    // ------------------------------------------------------------------
    logic full;
    logic ord_ne;
    logic head_wr;
    logic acc_rd, acc_wr;
    logic cap_rd, cap_wr;
    logic dlv_rd, dlv_wr;

    // Full is judged on registered occupancy only; a delivery in the same
    // cycle does not open a slot until the next cycle.
    assign full    = (ord_cnt_q == c_cnt_full);
    assign ord_ne  = (ord_cnt_q != c_cnt_zero);
    assign head_wr = ord_type_q[ord_rp_q];

    // Requests are gated by resetn so every request output reads 0 while
    // the block is held in reset, regardless of what the core drives.
    assign rd_req = resetn & data_req & ~data_wr & ~full & (wr_out_q == c_cnt_zero);
    assign wr_req = resetn & data_req &  data_wr & ~full;

    assign acc_rd       = rd_req & rd_addr_ok;
    assign acc_wr       = wr_req & wr_addr_ok;
    assign data_addr_ok = acc_rd | acc_wr;

    // A response with nothing issued on its channel is stale (e.g. from
    // before a reset) and is discarded.
    assign cap_rd = rd_data_ok & (rd_iss_q != c_cnt_zero);
    assign cap_wr = wr_data_ok & (wr_iss_q != c_cnt_zero);

    assign dlv_rd = ord_ne & ~head_wr & (rdf_cnt_q != c_cnt_zero);
    assign dlv_wr = ord_ne &  head_wr & (wr_done_q != c_cnt_zero);

    assign data_data_ok = dlv_rd | dlv_wr;
    assign data_rdata   = dlv_rd ? rdf_mem_q[rdf_rp_q] : 32'h0;
    assign busy         = ord_ne;

    assign rd_size  = data_size;
    assign rd_addr  = data_addr;
    assign wr_size  = data_size;
    assign wr_addr  = data_addr;
    assign wr_wdata = data_wdata;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        ord_type_d = ord_type_q;
        ord_wp_d   = ord_wp_q;
        ord_rp_d   = ord_rp_q;
        rdf_mem_d  = rdf_mem_q;
        rdf_wp_d   = rdf_wp_q;
        rdf_rp_d   = rdf_rp_q;

        if (data_addr_ok) begin
            ord_type_d[ord_wp_q] = acc_wr;
            ord_wp_d             = ord_wp_q + c_ptr_one;
        end
        if (data_data_ok) begin
            ord_rp_d = ord_rp_q + c_ptr_one;
        end

        if (cap_rd) begin
            rdf_mem_d[rdf_wp_q] = rd_rdata;
            rdf_wp_d            = rdf_wp_q + c_ptr_one;
        end
        if (dlv_rd) begin
            rdf_rp_d = rdf_rp_q + c_ptr_one;
        end

        // Simultaneous increment and decrement on one counter nets to zero.
        ord_cnt_d = ord_cnt_q + (data_addr_ok ? c_cnt_one : c_cnt_zero)
                              - (data_data_ok ? c_cnt_one : c_cnt_zero);
        rdf_cnt_d = rdf_cnt_q + (cap_rd ? c_cnt_one : c_cnt_zero)
                              - (dlv_rd ? c_cnt_one : c_cnt_zero);
        wr_out_d  = wr_out_q  + (acc_wr ? c_cnt_one : c_cnt_zero)
                              - (dlv_wr ? c_cnt_one : c_cnt_zero);
        rd_iss_d  = rd_iss_q  + (acc_rd ? c_cnt_one : c_cnt_zero)
                              - (cap_rd ? c_cnt_one : c_cnt_zero);
        wr_iss_d  = wr_iss_q  + (acc_wr ? c_cnt_one : c_cnt_zero)
                              - (cap_wr ? c_cnt_one : c_cnt_zero);
        wr_done_d = wr_done_q + (cap_wr ? c_cnt_one : c_cnt_zero)
                              - (dlv_wr ? c_cnt_one : c_cnt_zero);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < OUTSTANDING; i++) begin
                ord_type_q[i] <= 1'b0;
                rdf_mem_q[i]  <= 32'h0;
            end
            ord_wp_q  <= '0;
            ord_rp_q  <= '0;
            ord_cnt_q <= '0;
            rdf_wp_q  <= '0;
            rdf_rp_q  <= '0;
            rdf_cnt_q <= '0;
            wr_out_q  <= '0;
            rd_iss_q  <= '0;
            wr_iss_q  <= '0;
            wr_done_q <= '0;
        end else begin
            ord_type_q <= ord_type_d;
            rdf_mem_q  <= rdf_mem_d;
            ord_wp_q   <= ord_wp_d;
            ord_rp_q   <= ord_rp_d;
            ord_cnt_q  <= ord_cnt_d;
            rdf_wp_q   <= rdf_wp_d;
            rdf_rp_q   <= rdf_rp_d;
            rdf_cnt_q  <= rdf_cnt_d;
            wr_out_q   <= wr_out_d;
            rd_iss_q   <= rd_iss_d;
            wr_iss_q   <= wr_iss_d;
            wr_done_q  <= wr_done_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/data_req_splitter.md
Name: data_req_splitter

Overview:
- Sits between the CPU core's single SRAM-like data port and the AXI interface bridge's split read/write data ports.
- Steers each accepted request to the read or write channel.
- Tracks outstanding transactions and re-serialises responses so the core sees data_data_ok strictly in issue order.
- Enforces read-after-write ordering: a read is held while any write is outstanding.

Parameters:
- OUTSTANDING, 4, max accepted-but-undelivered requests (power of 2, 2..16).
- PTR_W, 2, log2(OUTSTANDING).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- data_req  in  1  core request valid
- data_wr  in  1  1=write, 0=read
- data_size  in  2  0=byte, 1=half, 2=word
- data_addr  in  32  byte address
- data_wdata  in  32  write data
- data_addr_ok  out  1  request accepted this cycle
- data_data_ok  out  1  oldest request complete this cycle
- data_rdata  out  32  read data, valid with data_data_ok on a read
- rd_req  out  1  read request to bridge
- rd_size  out  2  = data_size
- rd_addr  out  32  = data_addr
- rd_addr_ok  in  1  bridge accepted read
- rd_data_ok  in  1  read response valid
- rd_rdata  in  32  read response data
- wr_req  out  1  write request to bridge
- wr_size  out  2  = data_size
- wr_addr  out  32  = data_addr
- wr_wdata  out  32  = data_wdata
- wr_addr_ok  in  1  bridge accepted write address and data
- wr_data_ok  in  1  write response (B) received
- busy  out  1  any request outstanding

Behaviour:
- Reset is asynchronous. While resetn=0, all FIFOs, pointers and counters clear. All outputs read 0: data_addr_ok, data_data_ok, rd_req, wr_req, busy and data_rdata. Size, address and data pass-throughs are don't-care while the matching req is 0.
- Order FIFO: OUTSTANDING entries x 1 bit (type: 1=write). Push on every accepted request. Pop when data_data_ok=1.
- wr_out counter (0..OUTSTANDING): +1 on an accepted write, -1 when a write's data_data_ok is delivered.
- Issue logic is combinational, zero added latency:
  - full = order FIFO count == OUTSTANDING. Full is evaluated on registered state; a same-cycle pop does not free a slot.
  - rd_req = data_req & ~data_wr & ~full & (wr_out==0).
  - wr_req = data_req & data_wr & ~full.
  - data_addr_ok = (rd_req & rd_addr_ok) | (wr_req & wr_addr_ok).
  - The core holds its request until data_addr_ok. The bridge may assert addr_ok only while the matching req=1.
- Response capture:
  - Read data FIFO: OUTSTANDING x 32. Push rd_rdata when rd_data_ok=1 and reads are issued-but-uncaptured (>0).
  - wr_done counter: +1 when wr_data_ok=1 and writes are issued-but-uncaptured (>0).
  - A response arriving with nothing issued on that channel is dropped; state is unchanged.
  - Read/write responses may arrive in either relative order and at any cycle, including the accept cycle +1.
- Delivery (combinational from registered state):
  - data_data_ok = order FIFO non-empty & ((head=read & read data FIFO non-empty) | (head=write & wr_done>0)).
  - data_rdata = read data FIFO head when head=read; otherwise 0.
  - Minimum latency: response captured in cycle N, data_data_ok in cycle N+1.
  - One delivery per cycle. Capture and delivery in the same cycle on the same channel is legal: the counter/FIFO nets to unchanged.
- busy = order FIFO non-empty.
- Wrap-around: all pointers are modulo OUTSTANDING. Captured reads never exceed OUTSTANDING, so no overflow path exists.
- Reset mid-operation: everything clears. Bridge responses to pre-reset requests are dropped by the nothing-issued rule.

Test Plan:
- Single read: read of 0x1FC00000, size 2, rd_addr_ok=1 in cycle 0 -> data_addr_ok=1 in cycle 0. Then rd_data_ok with 0xDEADBEEF in cycle 3 -> data_data_ok=1 and data_rdata=0xDEADBEEF in cycle 4, busy=0 in cycle 5.
- Cross-channel reorder: read R0 accepted, then write W1 accepted. wr_data_ok arrives in cycle 2, rd_data_ok (0x12345678) in cycle 5 -> R0 delivered in cycle 6 with 0x12345678, then W1 delivered in cycle 7.
- RAW hold: write to 0x80 accepted, read of 0x80 presented next cycle -> rd_req=0 until the cycle after the write's data_data_ok, then rd_req=1.
- Full: 4 reads accepted with no responses. Fifth read -> rd_req=0 and data_addr_ok=0. One response arrives -> delivered next cycle; the cycle after that, the fifth read is accepted.
- Spurious: wr_data_ok=1 with nothing outstanding -> no data_data_ok, busy stays 0. A later write completes normally.
- Reset mid-operation: 2 reads outstanding, resetn pulsed low -> busy=0 immediately. Late rd_data_ok responses are ignored and data_data_ok stays 0.
